control_mac_fir: RTL and testbench
==================================

Name: control_mac_fir

Overview:
- Sequencer for the FIR multiply-accumulate datapath.
- Accepts one input sample per transaction over a valid/ready handshake and pulses the delay-line shift.
- Steps the coefficient/tap address across all taps and drives clear/enable of the 2·`N accumulator.
- Then loads the double-width output register and holds the result under a valid/ready handshake. Control only; no data bits pass through this block.

Parameters:
- TAPS, 8, number of filter taps; legal range 2..256.
- ADDR_W, 3, width of tap_addr; must satisfy 2^ADDR_W >= TAPS.
- MULT_LAT, 1, pipeline cycles from tap_addr valid to product valid at accumulator input; legal range 0..4.

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  upstream sample available
- in_ready  output  1  controller can accept a sample
- shift_en  output  1  one-cycle pulse: shift the new sample into the delay line
- tap_addr  output  ADDR_W  coefficient ROM / delay-line tap index
- addr_valid  output  1  tap_addr is a live MAC address this cycle
- acc_clr  output  1  synchronous clear of the 2·`N accumulator
- acc_en  output  1  accumulator adds the current product
- out_load  output  1  load enable for the 2·`N output register
- out_valid  output  1  output register holds an unconsumed result
- out_ready  input  1  downstream accepts the result
- busy  output  1  high in every state except IDLE

Behaviour:
- Reset (async, any state): state=IDLE. tap_addr=0, MULT_LAT delay line cleared. All 1-bit outputs 0 except in_ready=1.
- States: IDLE, SHIFT, MAC, FLUSH, LOAD, HOLD. Every output is a registered or state-decoded value; no combinational path from in_valid or out_ready to any output except in_ready.
- IDLE: in_ready=1. in_valid=1 at a rising edge -> SHIFT.
- SHIFT (1 cycle): shift_en=1, acc_clr=1, tap counter=0 -> MAC.
- MAC (exactly TAPS cycles):
  - addr_valid=1, tap_addr=k for k=0..TAPS-1, incrementing by 1 per cycle.
  - After k=TAPS-1: go to FLUSH if MULT_LAT>0, else LOAD.
- acc_en: addr_valid delayed by exactly MULT_LAT cycles through a shift register. MULT_LAT=0 makes acc_en coincide with addr_valid. acc_en is asserted exactly TAPS times per transaction.
- FLUSH (exactly MULT_LAT cycles): addr_valid=0, tap_addr held at TAPS-1, delayed acc_en drains -> LOAD.
- LOAD (1 cycle): out_load=1; acc_en is guaranteed 0 in this cycle -> HOLD.
- HOLD: out_valid=1 until out_ready=1 at a rising edge.
  - in_ready = out_ready in HOLD (back-to-back).
  - out_ready=1 and in_valid=1 -> SHIFT directly (result consumed and new sample accepted on the same edge).
  - out_ready=1 and in_valid=0 -> IDLE.
  - out_ready=0: stay; in_valid ignored.
- Latency: accept edge to first out_valid cycle = TAPS+MULT_LAT+3 cycles. Throughput with no backpressure in back-to-back mode: one result every TAPS+MULT_LAT+3 cycles.
- in_ready=0 in SHIFT, MAC, FLUSH, LOAD; in_valid is ignored there (no queuing).
- acc_clr and acc_en are never high in the same cycle. shift_en is never high during MAC.
- tap_addr never exceeds TAPS-1; the counter wraps to 0 only via SHIFT.
- Reset asserted mid-MAC: pending acc_en pulses are discarded; no out_load follows.

Test Plan:
- Reset mid-MAC at tap 3 (TAPS=8, MULT_LAT=1) -> next cycle all outputs at reset values, in_ready=1. No acc_en or out_load until a new accept.
- Single sample, TAPS=4, MULT_LAT=1, accept at edge 0:
  - shift_en/acc_clr in cycle 1; tap_addr 0,1,2,3 with addr_valid in cycles 2–5.
  - acc_en in cycles 3–6; out_load in cycle 7; out_valid from cycle 8.
  - busy high for cycles 1–8.
- MULT_LAT=0, TAPS=4 -> acc_en coincides with addr_valid in cycles 2–5, no FLUSH state, out_load in cycle 6, out_valid from cycle 7.
- Backpressure: out_ready=0 for 10 cycles in HOLD while in_valid=1 -> out_valid stays 1, in_ready=0, shift_en stays 0. Raising out_ready -> SHIFT on the next cycle.
- Back-to-back stream of 3 samples with out_ready=1 and in_valid=1 -> exactly 3 out_load pulses spaced TAPS+MULT_LAT+3 cycles apart, 3×TAPS acc_en pulses, no IDLE cycle between transactions.
- TAPS=5, ADDR_W=3, MULT_LAT=2 -> tap_addr sequence 0..4 then held at 4 for 2 FLUSH cycles; acc_en asserted 5 times; tap_addr never 5–7.

Source files
------------

// File: rtl/control_mac_fir.sv
// Sequencer for the FIR multiply-accumulate datapath: accepts a sample, walks every tap,
// drains the multiplier pipeline, loads the output register and holds the result.
module control_mac_fir #(
    parameter int unsigned TAPS     = 8,
    parameter int unsigned ADDR_W   = 3,
    parameter int unsigned MULT_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              shift_en,
    output logic [ADDR_W-1:0] tap_addr,
    output logic              addr_valid,
    output logic              acc_clr,
    output logic              acc_en,
    output logic              out_load,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy
);

    typedef enum logic [2:0] {StIdle, StShift, StMac, StFlush, StLoad, StHold} state_e;

    localparam logic [ADDR_W-1:0] LastTap   = ADDR_W'(TAPS - 1);
    localparam logic [2:0]        FlushLast = (MULT_LAT > 0) ? 3'(MULT_LAT - 1) : 3'd0;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] tap_q, tap_d;
    logic [2:0]        flush_q, flush_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            tap_q   <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            tap_q   <= tap_d;
            flush_q <= flush_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tap_d   = tap_q;
        flush_d = flush_q;
        case (state_q)
            StIdle: begin
                if (in_valid) state_d = StShift;
            end
            StShift: begin
                tap_d   = '0;
                state_d = StMac;
            end
            StMac: begin
                flush_d = '0;
                if (tap_q == LastTap) begin
                    state_d = (MULT_LAT > 0) ? StFlush : StLoad;
                end else begin
                    tap_d = tap_q + 1'b1;
                end
            end
            StFlush: begin
                flush_d = flush_q + 1'b1;
                if (flush_q == FlushLast) state_d = StLoad;
            end
            StLoad: begin
                state_d = StHold;
            end
            StHold: begin
                if (out_ready) state_d = in_valid ? StShift : StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        in_ready   = (state_q == StIdle) || ((state_q == StHold) && out_ready);
        shift_en   = (state_q == StShift);
        acc_clr    = (state_q == StShift);
        addr_valid = (state_q == StMac);
        out_load   = (state_q == StLoad);
        out_valid  = (state_q == StHold);
        busy       = (state_q != StIdle);
    end

    assign tap_addr = tap_q;

    // acc_en tracks addr_valid through the multiplier latency; reset drops anything in flight.
    if (MULT_LAT > 0) begin : g_lat
        logic [MULT_LAT-1:0] lat_q, lat_d;

        always_comb lat_d = MULT_LAT'({lat_q, addr_valid});

        always_ff @(posedge clk or posedge reset) begin
            if (reset) lat_q <= '0;
            else       lat_q <= lat_d;
        end

        assign acc_en = lat_q[MULT_LAT-1];
    end else begin : g_nolat
        assign acc_en = addr_valid;
    end

endmodule

// File: tb/tb_control_mac_fir.sv
// Randomized bench: several controller configurations share one stimulus stream and are each
// checked every cycle against a timeline model counted from the accept edge.
module tb_control_mac_fir;

    localparam int NCfg = 5;
    localparam int CfgTaps [NCfg] = '{8, 4, 4, 5, 2};
    localparam int CfgLat  [NCfg] = '{1, 1, 0, 2, 4};

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t observed=%h expected=%h", tag, $time, obs, exp);
        end
    endtask

    for (genvar i = 0; i < NCfg; i++) begin : g_cfg
        localparam int T  = CfgTaps[i];
        localparam int L  = CfgLat[i];
        localparam int AW = $clog2(T);

        logic          in_ready, shift_en, addr_valid, acc_clr, acc_en;
        logic          out_load, out_valid, busy;
        logic [AW-1:0] tap_addr;

        control_mac_fir #(
            .TAPS    (T),
            .ADDR_W  (AW),
            .MULT_LAT(L)
        ) u_dut (
            .clk       (clk),
            .reset     (reset),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .shift_en  (shift_en),
            .tap_addr  (tap_addr),
            .addr_valid(addr_valid),
            .acc_clr   (acc_clr),
            .acc_en    (acc_en),
            .out_load  (out_load),
            .out_valid (out_valid),
            .out_ready (out_ready),
            .busy      (busy)
        );

        // t = 0 when idle, otherwise cycles elapsed since the accepting edge.
        int t = 0;
        int tap_hold = 0;

        always @(posedge clk) begin
            if (reset) begin
                t        = 0;
                tap_hold = 0;
            end else if (t == 0) begin
                if (in_valid) t = 1;
            end else if (t >= T + L + 3) begin
                if (out_ready) t = in_valid ? 1 : 0;
            end else begin
                if (t == T + 1) tap_hold = T - 1;
                t = t + 1;
            end
        end

        always @(negedge clk) begin
            logic [15:0] exp_v, obs_v;
            logic        hold, av;
            int          u;
            if (reset) begin
                exp_v = 16'h8000;
            end else begin
                u    = t - L;
                hold = (t >= T + L + 3);
                av   = (t >= 2) && (t <= T + 1);
                exp_v = {(t == 0) || (hold && out_ready),
                         t == 1,
                         t == 1,
                         av,
                         (u >= 2) && (u <= T + 1),
                         t == T + L + 2,
                         hold,
                         t != 0,
                         av ? 8'(t - 2) : 8'(tap_hold)};
            end
            obs_v = {in_ready, shift_en, acc_clr, addr_valid, acc_en,
                     out_load, out_valid, busy, 8'(tap_addr)};
            check_eq($sformatf("cfg%0d_T%0d_L%0d", i, T, L), 32'(obs_v), 32'(exp_v));
        end
    end

    task automatic drive(input logic iv, input logic ordy, input logic rst);
        @(posedge clk);
        #2;
        in_valid  = iv;
        out_ready = ordy;
        reset     = rst;
    endtask

    initial begin
        repeat (3) drive(1'b0, 1'b0, 1'b1);
        repeat (5) drive(1'b0, 1'b1, 1'b0);

        // Single accept then reset in the middle of MAC.
        drive(1'b1, 1'b1, 1'b0);
        repeat (4) drive(1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b1);
        repeat (20) drive(1'b0, 1'b1, 1'b0);

        // Back-to-back stream with no backpressure.
        repeat (60) drive(1'b1, 1'b1, 1'b0);
        repeat (20) drive(1'b0, 1'b1, 1'b0);

        // Result held under backpressure while a new sample waits.
        repeat (40) drive(1'b1, 1'b0, 1'b0);
        repeat (3) drive(1'b1, 1'b1, 1'b0);
        repeat (20) drive(1'b0, 1'b1, 1'b0);

        for (int n = 0; n < 3000; n++) begin
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 249) == 0));
        end
        repeat (20) drive(1'b0, 1'b1, 1'b0);

        @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
